mmio_timer_responder: RTL
=========================

// Module: mmio_timer_responder
// PURPOSE
//  Memory-mapped timer peripheral; bus responder to the core's memory-map decoder (initiator), same Address/DataIn/DataOut/Select/Write
//  interface as the GPIO and UART ports. Free-running/one-shot 32-bit counter with prescaler, compare match, sticky status and IRQ line.
//  Sits beside GPIO_Port/UART port behind the decoder; software polls STATUS or uses Irq.
// PARAMETERS
//  DATA_LENGTH      32            bus data width
//  PRESCALE_WIDTH   16            prescaler register/counter width
//  RST_COMPARE      32'hFFFF_FFFF COMPARE reset value
// PORTS
//  clk        in   1   single system clock
//  rst        in   1   asynchronous, active-low reset
//  Address    in   32  byte address from decoder; only Address[4:2] decoded
//  DataIn     in   32  write data from core (B register)
//  DataOut    out  32  read data to core
//  Select     in   1   chip select from decoder
//  Write      in   1   write strobe (valid only with Select)
//  Match      out  1   one-cycle pulse on compare match
//  Irq        out  1   level: STATUS.MATCH & CTRL.IE
// BEHAVIOUR
//  Registers (word index = Address[4:2]): 0 CTRL [0]EN [1]RELOAD [2]IE [3]CLR; 1 PRESCALE; 2 COMPARE; 3 COUNT; 4 STATUS [0]MATCH.
//  Indices 5-7: reads 0, writes ignored. Unused bits read 0.
//  Reset (rst=0, async): CTRL=0, PRESCALE=0, COMPARE=RST_COMPARE, COUNT=0, STATUS=0, prescaler cnt=0, state IDLE; Match=0, Irq=0.
//  Read: combinational, DataOut = reg[idx] when Select, else 32'd0; zero latency (core captures in data register next edge).
//  Write: registered on clk when Select&Write; effective next cycle.
//  CLR: write-1 self-clearing; zeroes COUNT and prescaler cnt that edge; reads 0.
//  STATUS.MATCH: write-1-to-clear; write 0 no effect.
//  Prescaler: pcnt counts 0..PRESCALE while RUN; tick when pcnt==PRESCALE, pcnt<=0. PRESCALE=0 -> tick every cycle.
//  FSM: IDLE (EN=0): count/pcnt hold. RUN: on tick COUNT<=COUNT+1 (mod 2^32, wrap silent).
//       HALT: one-shot finished; count holds.
//   IDLE->RUN: EN written 1 (pcnt cleared on entry). RUN/HALT->IDLE: EN written 0.
//   RUN, tick, COUNT==COMPARE: Match=1 next cycle, MATCH<=1; RELOAD=1 -> COUNT<=0, stay RUN;
//     RELOAD=0 -> COUNT holds, ->HALT.
//   HALT->RUN: write to COUNT or CLR while EN=1.
//  Priority (same cycle): CPU write to COUNT/CLR > tick increment; MATCH set > W1C clear; EN=0 write > match transition.
//  Match detect compares current COUNT before increment; COMPARE written equal to COUNT mid-prescale matches on next tick.
//  Irq combinational from registered bits; no glitch on reads.
//  Reset mid-count: all state returns to reset values immediately, Match deasserts asynchronously.
// STRUCTURE
//  Shared pkg/include: register index constants, CTRL/STATUS bit positions, FSM state encodings (IDLE/RUN/HALT, 2b).
//  Sub-module: timer_prescaler (PRESCALE_WIDTH counter, clr, en, tick out).
//  Top: register bank + read mux + FSM + 32b counter/comparator.
// TESTING
//  Reset: rst low mid-RUN -> all regs read reset values, Match=0, Irq=0, COUNT reads 0.
//  PRESCALE=0, COMPARE=5, CTRL=EN|RELOAD -> Match pulses every 6 cycles, COUNT sequence 0..5,0.
//  PRESCALE=3, COMPARE=2, CTRL=EN (one-shot) -> Match once ~12 cycles after enable, COUNT holds 2, state HALT; write COUNT=0 -> resumes.
//  CTRL=EN|IE, match -> Irq=1; write STATUS=1 same cycle as new match -> MATCH stays 1; next clear cycle -> Irq=0.
//  COUNT=32'hFFFF_FFFE, COMPARE=3, PRESCALE=0 -> wraps to 0 with no Match, Match at COUNT=3.
//  Write COUNT=100 on tick cycle -> reads 100 (write wins); read idx 6 -> 0; Select=0 -> DataOut=0, writes ignored.

Source files
------------

// File: rtl/mmio_timer_responder_pkg.sv
// Shared definitions for the MMIO timer: register word indices, CTRL/STATUS bit
// positions and the timer FSM state encoding.
package mmio_timer_responder_pkg;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_COMPARE  = 3'd2;
    localparam logic [2:0] IDX_COUNT    = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IE     = 2;
    localparam int unsigned CTRL_CLR    = 3;
    // Only EN/RELOAD/IE are stored; CLR is a self-clearing strobe.
    localparam int unsigned CTRL_BITS   = 3;

    localparam int unsigned STATUS_MATCH = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the MMIO timer: counts 0..prescale while enabled and emits a
// one-cycle tick on the terminal count.
module timer_prescaler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] prescale_i,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pcnt_q, pcnt_d;

    assign tick_o = en_i && (pcnt_q == prescale_i);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = tick_o ? '0 : pcnt_q + One;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer responder: register bank, combinational read mux, run/halt
// FSM and 32-bit counter with compare match, sticky status and IRQ.
module mmio_timer_responder
    import mmio_timer_responder_pkg::*;
#(
    parameter int unsigned             DATA_LENGTH    = 32,
    parameter int unsigned             PRESCALE_WIDTH = 16,
    parameter logic [DATA_LENGTH-1:0]  RST_COMPARE    = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            Address,
    input  logic [DATA_LENGTH-1:0] DataIn,
    output logic [DATA_LENGTH-1:0] DataOut,
    input  logic                   Select,
    input  logic                   Write,
    output logic                   Match,
    output logic                   Irq
);

    localparam logic [DATA_LENGTH-1:0] CountOne = {{(DATA_LENGTH-1){1'b0}}, 1'b1};

    logic [2:0] idx;
    logic       wr_en, ctrl_wr, presc_wr, cmp_wr, cnt_wr, status_wr, clr_wr;
    logic       tick, hit, run_en, pcnt_clr;

    logic [CTRL_BITS-1:0]      ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [DATA_LENGTH-1:0]    compare_q, compare_d;
    logic [DATA_LENGTH-1:0]    count_q, count_d;
    logic                      match_flag_q, match_flag_d;
    logic                      match_pulse_q, match_pulse_d;
    timer_state_e              state_q, state_d;

    logic unused_addr;
    assign unused_addr = ^{Address[31:5], Address[1:0]};

    assign idx       = Address[4:2];
    assign wr_en     = Select && Write;
    assign ctrl_wr   = wr_en && (idx == IDX_CTRL);
    assign presc_wr  = wr_en && (idx == IDX_PRESCALE);
    assign cmp_wr    = wr_en && (idx == IDX_COMPARE);
    assign cnt_wr    = wr_en && (idx == IDX_COUNT);
    assign status_wr = wr_en && (idx == IDX_STATUS);
    assign clr_wr    = ctrl_wr && DataIn[CTRL_CLR];

    assign run_en   = (state_q == StRun);
    // The prescaler restarts on CLR and whenever the timer is freshly enabled from idle.
    assign pcnt_clr = clr_wr || ((state_q == StIdle) && ctrl_wr && DataIn[CTRL_EN]);
    assign hit      = tick && (count_q == compare_q);

    timer_prescaler #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pcnt_clr),
        .en_i       (run_en),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );

    always_comb begin
        ctrl_d        = ctrl_q;
        prescale_d    = prescale_q;
        compare_d     = compare_q;
        count_d       = count_q;
        match_flag_d  = match_flag_q;
        match_pulse_d = hit;

        if (ctrl_wr)  ctrl_d     = DataIn[CTRL_BITS-1:0];
        if (presc_wr) prescale_d = DataIn[PRESCALE_WIDTH-1:0];
        if (cmp_wr)   compare_d  = DataIn;

        if (tick) begin
            if (hit) begin
                count_d = ctrl_q[CTRL_RELOAD] ? '0 : count_q;
            end else begin
                count_d = count_q + CountOne;
            end
        end
        // CPU writes override whatever the tick would have done.
        if (clr_wr) count_d = '0;
        if (cnt_wr) count_d = DataIn;

        if (hit) begin
            match_flag_d = 1'b1;
        end else if (status_wr && DataIn[STATUS_MATCH]) begin
            match_flag_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_wr && !DataIn[CTRL_EN]) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (ctrl_wr && DataIn[CTRL_EN]) state_d = StRun;
                StRun: begin
                    if (hit && !ctrl_q[CTRL_RELOAD] && !clr_wr && !cnt_wr) state_d = StHalt;
                end
                StHalt: if (clr_wr || cnt_wr) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q        <= '0;
            prescale_q    <= '0;
            compare_q     <= RST_COMPARE;
            count_q       <= '0;
            match_flag_q  <= 1'b0;
            match_pulse_q <= 1'b0;
            state_q       <= StIdle;
        end else begin
            ctrl_q        <= ctrl_d;
            prescale_q    <= prescale_d;
            compare_q     <= compare_d;
            count_q       <= count_d;
            match_flag_q  <= match_flag_d;
            match_pulse_q <= match_pulse_d;
            state_q       <= state_d;
        end
    end

    always_comb begin
        DataOut = '0;
        if (Select) begin
            case (idx)
                IDX_CTRL:     DataOut = {{(DATA_LENGTH-CTRL_BITS){1'b0}}, ctrl_q};
                IDX_PRESCALE: DataOut = {{(DATA_LENGTH-PRESCALE_WIDTH){1'b0}}, prescale_q};
                IDX_COMPARE:  DataOut = compare_q;
                IDX_COUNT:    DataOut = count_q;
                IDX_STATUS:   DataOut = {{(DATA_LENGTH-1){1'b0}}, match_flag_q};
                default:      DataOut = '0;
            endcase
        end
    end

    assign Match = match_pulse_q;
    assign Irq   = match_flag_q && ctrl_q[CTRL_IE];

endmodule
